// File: rtl/mar_seq.sv
// mar_seq : memory address register with load, increment and self-timed
// read bursts toward RAM.
//
// The address is captured from the shared bus, stepped by one on request,
// or swept through a burst of 1..2^LEN_W beats. Each beat is handed to RAM
// with a req/ready handshake. The address wraps modulo DEPTH, and DEPTH does
// not have to be a power of two.
//
// Parameters
//   BUS_W   bus width
//   ADDR_W  address width (ADDR_W <= BUS_W)
//   DEPTH   number of valid locations (2 <= DEPTH <= 2^ADDR_W)
//   LEN_W   width of the burst-length field
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_rst          synchronous reset, active-high
//   i_load         capture i_bus[ADDR_W-1:0] into the address
//   i_inc          advance the address by one
//   i_bus          shared data bus
//   i_burst_start  begin a burst from the current (or just-loaded) address
//   i_burst_len    beats minus one
//   i_mem_ready    RAM accepts the beat presented this cycle
//   o_address      registered address to RAM
//   o_mem_req      beat request, high throughout BURST
//   o_busy         high in BURST and DONE
//   o_burst_done   one-cycle pulse after the final beat
//   o_wrap         one-cycle pulse when the address wraps DEPTH-1 -> 0
//   o_range_err    one-cycle pulse when a load captures a value >= DEPTH
module mar_seq #(
   parameter int BUS_W  = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic              i_inc,
   input  logic [BUS_W-1:0]  i_bus,
   input  logic              i_burst_start,
   input  logic [LEN_W-1:0]  i_burst_len,
   input  logic              i_mem_ready,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_mem_req,
   output logic              o_busy,
   output logic              o_burst_done,
   output logic              o_wrap,
   output logic              o_range_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // The last valid location, held at ADDR_W+1 bits so that
   // DEPTH = 2^ADDR_W compares cleanly.
   localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_cnt;
   logic [LEN_W-1:0]    w_cnt_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_wrap_nxt;
   logic                w_rerr_nxt;
   logic                r_mem_req;
   logic                r_busy;
   logic                r_burst_done;
   logic                r_wrap;
   logic                r_range_err;

   // Increment and load candidates.
   logic [ADDR_W:0]     w_inc_full;
   logic                w_at_last;
   logic [ADDR_W-1:0]   w_inc_addr;
   logic [ADDR_W-1:0]   w_bus_addr;
   logic                w_bus_oor;
   logic [ADDR_W-1:0]   w_load_addr;

   // Only the low ADDR_W bus bits carry an address. The rest of the bus is
   // folded into a deliberately unused net.
   logic                w_unused_bus;
   assign w_unused_bus = ^i_bus;

   // Successor address, worked out at ADDR_W+1 bits. The compare against
   // DEPTH-1 replaces a modulo operation.
   assign w_inc_full = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
   assign w_at_last  = ({1'b0, r_addr} == DEPTH_M1);
   assign w_inc_addr = w_at_last ? {ADDR_W{1'b0}} : w_inc_full[ADDR_W-1:0];

   // A loaded value at or beyond DEPTH is clamped to location 0.
   assign w_bus_addr  = i_bus[ADDR_W-1:0];
   assign w_bus_oor   = ({1'b0, w_bus_addr} > DEPTH_M1);
   assign w_load_addr = w_bus_oor ? {ADDR_W{1'b0}} : w_bus_addr;

   // Next-state, next-address and event-pulse decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_wrap_nxt  = 1'b0;
      w_rerr_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_burst_start) begin
               // A simultaneous load sets where the burst starts. inc is dropped.
               if (i_load) begin
                  w_addr_nxt = w_load_addr;
                  w_rerr_nxt = w_bus_oor;
               end else begin
                  w_addr_nxt = r_addr;
               end
               w_cnt_nxt   = i_burst_len;
               w_state_nxt = S_BURST;
            end else if (i_load) begin
               w_addr_nxt = w_load_addr;
               w_rerr_nxt = w_bus_oor;
            end else if (i_inc) begin
               w_addr_nxt = w_inc_addr;
               w_wrap_nxt = w_at_last;
            end else begin
               w_addr_nxt = r_addr;
            end
         end
         S_BURST: begin
            // mem_req is high for the whole of BURST, so ready alone accepts a beat.
            if (i_mem_ready) begin
               if (r_cnt != {LEN_W{1'b0}}) begin
                  w_cnt_nxt  = r_cnt - LEN_W'(1);
                  w_addr_nxt = w_inc_addr;
                  w_wrap_nxt = w_at_last;
               end else begin
                  // Final beat: the address stays on it.
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_state_nxt = S_BURST;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counter, address and registered outputs. Each output flag is
   // decoded from the next state, so it changes on the same edge as the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= {LEN_W{1'b0}};
         r_addr       <= {ADDR_W{1'b0}};
         r_mem_req    <= 1'b0;
         r_busy       <= 1'b0;
         r_burst_done <= 1'b0;
         r_wrap       <= 1'b0;
         r_range_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_addr       <= w_addr_nxt;
         r_mem_req    <= (w_state_nxt == S_BURST);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_burst_done <= (w_state_nxt == S_DONE);
         r_wrap       <= w_wrap_nxt;
         r_range_err  <= w_rerr_nxt;
      end
   end

   assign o_address    = r_addr;
   assign o_mem_req    = r_mem_req;
   assign o_busy       = r_busy;
   assign o_burst_done = r_burst_done;
   assign o_wrap       = r_wrap;
   assign o_range_err  = r_range_err;

endmodule

// File: tb/tb_mar_seq.sv
// tb_mar_seq : directed testbench for mar_seq. It builds one instance with
// the default geometry (DEPTH=16) and one with DEPTH=12. Expected values are
// hand-computed constants.
module tb_mar_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       load, inc, burst_start, mem_ready;
   logic [7:0] bus;
   logic [3:0] burst_len;
   logic [3:0] address;
   logic       mem_req, busy, burst_done, wrap, range_err;

   logic       load12, inc12;
   logic [7:0] bus12;
   logic [3:0] address12;
   logic       mem_req12, busy12, burst_done12, wrap12, range_err12;
   logic       bs12, rdy12;
   logic [3:0] len12;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mar_seq #(.BUS_W(8), .ADDR_W(4), .DEPTH(16), .LEN_W(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_load(load), .i_inc(inc), .i_bus(bus),
      .i_burst_start(burst_start), .i_burst_len(burst_len),
      .i_mem_ready(mem_ready), .o_address(address), .o_mem_req(mem_req),
      .o_busy(busy), .o_burst_done(burst_done), .o_wrap(wrap),
      .o_range_err(range_err)
   );

   mar_seq #(.BUS_W(8), .ADDR_W(4), .DEPTH(12), .LEN_W(4)) dut12 (
      .i_clk(clk), .i_rst(rst), .i_load(load12), .i_inc(inc12), .i_bus(bus12),
      .i_burst_start(bs12), .i_burst_len(len12),
      .i_mem_ready(rdy12), .o_address(address12), .o_mem_req(mem_req12),
      .o_busy(busy12), .o_burst_done(burst_done12), .o_wrap(wrap12),
      .o_range_err(range_err12)
   );

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge, then settle 1 time unit past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Flag vector: {mem_req, busy, burst_done, wrap, range_err}
   function automatic logic [31:0] flags();
      return {27'd0, mem_req, busy, burst_done, wrap, range_err};
   endfunction

   int         done_cnt;
   int         busy_cnt;
   int         wrap_cnt;
   logic [3:0] stall_rdy  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [3:0] stall_addr [6] = '{4'd7, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9};
   logic       stall_req  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [3:0] wr_addr    [6] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd1, 4'd1};
   logic       wr_busy    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic       wr_wrap    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst = 1'b1; load = 1'b0; inc = 1'b0; burst_start = 1'b0;
      mem_ready = 1'b0; bus = 8'h00; burst_len = 4'd0;
      load12 = 1'b0; inc12 = 1'b0; bus12 = 8'h00; bs12 = 1'b0;
      rdy12 = 1'b0; len12 = 4'd0;

      // Reset
      step(); step();
      check_val("rst_addr", 32'(address), 32'd0);
      check_val("rst_flags", flags(), 32'd0);
      check_val("rst_addr12", 32'(address12), 32'd0);

      // Load, including ignored upper bus bits
      rst = 1'b0; load = 1'b1; bus = 8'h1C;
      step();
      check_val("load_1C", 32'(address), 32'd12);
      check_val("load_1C_rerr", 32'(range_err), 32'd0);
      bus = 8'h4B;
      step();
      check_val("load_4B", 32'(address), 32'd11);
      load = 1'b0; bus = 8'hFF;
      step();
      check_val("hold_11", 32'(address), 32'd11);

      // Increment wrap at DEPTH-1
      load = 1'b1; bus = 8'h0F;
      step();
      check_val("load_0F", 32'(address), 32'd15);
      load = 1'b0; inc = 1'b1;
      step();
      check_val("inc_wrap_addr", 32'(address), 32'd0);
      check_val("inc_wrap_flag", 32'(wrap), 32'd1);
      step();
      check_val("inc_1_addr", 32'(address), 32'd1);
      check_val("inc_1_wrap", 32'(wrap), 32'd0);
      inc = 1'b0;

      // Burst with stalls
      load = 1'b1; bus = 8'h06;
      step();
      check_val("load_06", 32'(address), 32'd6);
      load = 1'b0; burst_start = 1'b1; burst_len = 4'd3; mem_ready = 1'b0;
      step();
      check_val("bst_start_addr", 32'(address), 32'd6);
      check_val("bst_start_flags", flags(), 32'b11000);
      burst_start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         mem_ready = stall_rdy[i][0];
         step();
         check_val($sformatf("stall_addr%0d", i), 32'(address), 32'(stall_addr[i]));
         check_val($sformatf("stall_req%0d", i), 32'(mem_req), 32'(stall_req[i]));
         if (burst_done) done_cnt++;
      end
      check_val("stall_done_busy", 32'(busy), 32'd1);
      mem_ready = 1'b0;
      step();
      if (burst_done) done_cnt++;
      check_val("stall_idle_flags", flags(), 32'd0);
      check_val("stall_done_cnt", 32'(done_cnt), 32'd1);
      check_val("stall_end_addr", 32'(address), 32'd9);

      // Burst with wrap and simultaneous load
      load = 1'b1; bus = 8'h0E; burst_start = 1'b1; burst_len = 4'd3;
      mem_ready = 1'b1;
      busy_cnt = 0; wrap_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         load = 1'b0; burst_start = 1'b0;
         check_val($sformatf("wr_addr%0d", i), 32'(address), 32'(wr_addr[i]));
         check_val($sformatf("wr_busy%0d", i), 32'(busy), 32'(wr_busy[i]));
         check_val($sformatf("wr_wrap%0d", i), 32'(wrap), 32'(wr_wrap[i]));
         if (busy) busy_cnt++;
         if (wrap) wrap_cnt++;
      end
      check_val("wr_busy_cycles", 32'(busy_cnt), 32'd5);
      check_val("wr_wrap_count", 32'(wrap_cnt), 32'd1);

      // Non-power-of-two depth
      load12 = 1'b1; bus12 = 8'h0D;
      step();
      check_val("d12_oor_addr", 32'(address12), 32'd0);
      check_val("d12_oor_rerr", 32'(range_err12), 32'd1);
      bus12 = 8'h0B;
      step();
      check_val("d12_load_11", 32'(address12), 32'd11);
      check_val("d12_rerr_clear", 32'(range_err12), 32'd0);
      load12 = 1'b0; inc12 = 1'b1;
      step();
      check_val("d12_wrap_addr", 32'(address12), 32'd0);
      check_val("d12_wrap_flag", 32'(wrap12), 32'd1);
      inc12 = 1'b0;

      // Reset mid-burst
      mem_ready = 1'b1; load = 1'b1; bus = 8'h03;
      step();
      load = 1'b0; burst_start = 1'b1; burst_len = 4'd7;
      step();
      check_val("mid_start_addr", 32'(address), 32'd3);
      burst_start = 1'b0;
      step(); step();
      check_val("mid_2beats", 32'(address), 32'd5);
      rst = 1'b1;
      step();
      check_val("mid_rst_addr", 32'(address), 32'd0);
      check_val("mid_rst_flags", flags(), 32'd0);
      rst = 1'b0;
      step();
      check_val("mid_after_flags", flags(), 32'd0);

      // Load and inc ignored during BURST and DONE
      load = 1'b1; bus = 8'h02;
      step();
      load = 1'b0; burst_start = 1'b1; burst_len = 4'd2;
      step();
      check_val("ign_start", 32'(address), 32'd2);
      burst_start = 1'b0; load = 1'b1; bus = 8'h0A; inc = 1'b1;
      step();
      check_val("ign_b1", 32'(address), 32'd3);
      step();
      check_val("ign_b2", 32'(address), 32'd4);
      step();
      check_val("ign_done_addr", 32'(address), 32'd4);
      check_val("ign_done_pulse", 32'(burst_done), 32'd1);
      step();
      check_val("ign_done_hold", 32'(address), 32'd4);
      step();
      check_val("ign_idle_load", 32'(address), 32'd10);
      load = 1'b0; inc = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mar_seq.md
# mar_seq

Parametrised successor to the SAP-1 memory address register. Captures an address from the shared bus, steps it by one on request, and runs self-timed read bursts toward RAM with a req/ready handshake and modulo-DEPTH wrap. It sits between the bus and the RAM address port. With `inc` and `burst_start` tied low it behaves as a plain load-only MAR.

## Interface
- `BUS_W`, default 8: bus width.
- `ADDR_W`, default 4: address width. Must satisfy ADDR_W ≤ BUS_W.
- `DEPTH`, default 16: number of valid locations. Requires 2 ≤ DEPTH ≤ 2^ADDR_W; DEPTH need not be a power of two.
- `LEN_W`, default 4: width of the burst-length field.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `load` in 1: capture the bus into the address.
- `inc` in 1: advance the address by one.
- `bus` in BUS_W: shared data bus. Only bits [ADDR_W-1:0] are used.
- `burst_start` in 1: begin a burst from the current (or simultaneously loaded) address.
- `burst_len` in LEN_W: number of beats minus 1, so a burst is 1..2^LEN_W beats.
- `mem_ready` in 1: RAM accepts the beat presented this cycle.
- `address` out ADDR_W: registered address to RAM.
- `mem_req` out 1: beat request, high throughout BURST.
- `busy` out 1: high in BURST and DONE.
- `burst_done` out 1: one-cycle pulse after the final beat.
- `wrap` out 1: one-cycle pulse when the address wraps from DEPTH-1 to 0.
- `range_err` out 1: one-cycle pulse when a load captures a value ≥ DEPTH.

## Operation
- States: IDLE, BURST, DONE.
- Reset (`rst`=1 at an edge) overrides everything, including a burst in progress:
  - address = 0, state = IDLE, beat counter = 0.
  - mem_req, busy, burst_done, wrap and range_err all 0.
- IDLE:
  - Priority is burst_start > load > inc, with one exception: load and burst_start together load first, then start the burst at the loaded address.
  - load: address ← bus[ADDR_W-1:0]. If that value ≥ DEPTH, address ← 0 and range_err pulses.
  - inc (without load): address ← address+1. At DEPTH-1 it goes to 0 and wrap pulses.
  - burst_start: beat counter ← burst_len, go to BURST. inc is ignored that cycle.
- BURST:
  - mem_req = 1 and address is held stable until a beat is accepted.
  - A beat is accepted on an edge where mem_req && mem_ready.
  - On an accepted beat with counter ≠ 0: counter−1, and address increments with modulo-DEPTH wrap, pulsing wrap.
  - On an accepted beat with counter = 0: address holds (it stays at the final beat address), go to DONE.
  - load, inc and burst_start are ignored in BURST.
- DONE: mem_req = 0 and burst_done = 1 for exactly one cycle, then IDLE. load, inc and burst_start are ignored.
- Arithmetic:
  - Address increment is computed at ADDR_W+1 bits and compared against DEPTH-1; no modulo operator is used.
  - The beat counter is LEN_W bits wide.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- load and inc take effect in `address` one cycle after the sampling edge.
- mem_req rises on the edge that accepts burst_start.
- Throughput is one beat per cycle while mem_ready stays high. With mem_ready held high, a burst of N beats keeps mem_req high for N cycles.
- burst_done rises on the edge that accepts the last beat and falls one cycle later. IDLE accepts commands on the next edge.
- mem_ready while mem_req = 0 has no effect.
- wrap and range_err are high for exactly one cycle per event and coincide with the address update that caused them.
- Reset applied mid-burst drops mem_req at that edge; no burst_done pulse is produced.

## Test plan
- Reset and load (defaults): rst=1 → address=0, all flags 0. Release rst, load with bus=8'h1C → address=12; bus=8'h4B → 11; load=0, bus=8'hFF → address holds at 11.
- Increment wrap: load 8'h0F, then pulse inc → address=0 with wrap=1 for one cycle. A further inc → address=1, wrap=0.
- Burst with stalls: load 8'h06, burst_start with burst_len=3, mem_ready toggling 1,0,1,1,0,1:
  - address steps 6, 7, 8, 9 only on accepted beats.
  - mem_req high through 4 accepted beats; burst_done pulses once; address ends at 9.
- Burst wrap with simultaneous load: load=1, bus=8'h0E and burst_start=1 with burst_len=3 in the same cycle, mem_ready=1 → addresses 14, 15, 0, 1; one wrap pulse; busy for 5 cycles.
- Non-power-of-two depth (DEPTH=12):
  - load 8'h0D → address=0 with range_err=1.
  - load 8'h0B, inc → address=0 with wrap=1.
- Reset mid-burst and ignored commands:
  - burst_len=7, assert rst after 2 beats → address=0, mem_req=0, no burst_done.
  - In a fresh burst, load and inc asserted during BURST → address sequence unchanged.
